// File: rtl/bus_datapath_seq.sv
// Single shared-bus register datapath with a built-in microsequencer.
// A start/done handshake runs one 3-operand operation as a fixed series of
// bus transfers. The register file, HI/LO, MDR, Y and a double-width Z all
// exchange data over one internal bus that has a one-hot source select.
`timescale 1ns/1ps
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ZERO_R0  = 0
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [$clog2(NUM_REGS)-1:0] ra,
  input  logic [$clog2(NUM_REGS)-1:0] rb,
  input  logic [$clog2(NUM_REGS)-1:0] rc,
  input  logic [DATA_W-1:0]           mdatain,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           bus_out,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data,
  output logic [DATA_W-1:0]           hi_out,
  output logic [DATA_W-1:0]           lo_out
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_LDM  = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;

  // One-hot bus source positions
  localparam int SRC_RB  = 0;
  localparam int SRC_RC  = 1;
  localparam int SRC_ZLO = 2;
  localparam int SRC_ZHI = 3;
  localparam int SRC_MDR = 4;
  localparam int SRC_HI  = 5;
  localparam int SRC_LO  = 6;
  localparam int SRC_MEM = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_TY, S_TZ, S_TLO, S_THI, S_TMDR, S_TWB, S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [2:0]            op_q;
  logic [IDX_W-1:0]      ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]     y, mdr, hi, lo;
  logic [2*DATA_W-1:0]   z, z_nx;
  logic [DATA_W-1:0]     bus;
  logic [7:0]            src;
  logic [NUM_REGS-1:0]   reg_we;
  logic [DATA_W-1:0]     regs [NUM_REGS];

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] code,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (code)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic signed [2*DATA_W-1:0] mul_full(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae, be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  // Register file: R0 is hard-wired to zero on the read side when ZERO_R0 is set
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q;
    // Load the bus when the write-back T-state targets this register
    always_ff @(posedge clock) begin
      if (clear) q <= '0;
      else if (reg_we[gi]) q <= bus;
    end
    assign regs[gi] = (ZERO_R0 != 0 && gi == 0) ? '0 : q;
  end

  // Select exactly one bus source per T-state; IDLE and DONE leave the bus at zero
  always_comb begin
    src = '0;
    case (state)
      S_TY:   src[SRC_RB]  = 1'b1;
      S_TZ:   src[SRC_RC]  = 1'b1;
      S_TLO:  src[SRC_ZLO] = 1'b1;
      S_THI:  src[SRC_ZHI] = 1'b1;
      S_TMDR: src[SRC_MEM] = 1'b1;
      S_TWB: begin
        case (op_q)
          OP_LDM:  src[SRC_MDR] = 1'b1;
          OP_MFHI: src[SRC_HI]  = 1'b1;
          3'd7:    src[SRC_LO]  = 1'b1;
          default: src[SRC_ZLO] = 1'b1;
        endcase
      end
      default: src = '0;
    endcase
  end

  assign bus = ({DATA_W{src[SRC_RB]}}  & regs[rb_q])
             | ({DATA_W{src[SRC_RC]}}  & regs[rc_q])
             | ({DATA_W{src[SRC_ZLO]}} & z[DATA_W-1:0])
             | ({DATA_W{src[SRC_ZHI]}} & z[2*DATA_W-1:DATA_W])
             | ({DATA_W{src[SRC_MDR]}} & mdr)
             | ({DATA_W{src[SRC_HI]}}  & hi)
             | ({DATA_W{src[SRC_LO]}}  & lo)
             | ({DATA_W{src[SRC_MEM]}} & mdatain);

  // Z result: full signed product for MUL, zero-extended ALU result otherwise
  always_comb begin
    z_nx = (op_q == OP_MUL) ? mul_full(y, bus) : {{DATA_W{1'b0}}, alu(op_q, y, bus)};
  end

  // Register-file write strobe; writes to R0 are dropped when it is hard-wired
  always_comb begin
    reg_we = '0;
    if (state == S_TWB && !(ZERO_R0 != 0 && ra_q == '0)) reg_we[ra_q] = 1'b1;
  end

  // T-state sequencing: each op walks a fixed path and always ends with DONE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op <= OP_MUL)     state_nx = S_TY;
          else if (op == OP_LDM) state_nx = S_TMDR;
          else                   state_nx = S_TWB;
        end
      end
      S_TY:    state_nx = S_TZ;
      S_TZ:    state_nx = (op_q == OP_MUL) ? S_TLO : S_TWB;
      S_TLO:   state_nx = S_THI;
      S_THI:   state_nx = S_DONE;
      S_TMDR:  state_nx = S_TWB;
      S_TWB:   state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state, registered handshake outputs and bus destinations
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      y     <= '0;
      z     <= '0;
      mdr   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
      if (state == S_IDLE && start) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      case (state)
        S_TY:    y   <= bus;
        S_TZ:    z   <= z_nx;
        S_TLO:   lo  <= bus;
        S_THI:   hi  <= bus;
        S_TMDR:  mdr <= bus;
        default: ;
      endcase
    end
  end

  assign bus_out  = bus;
  assign dbg_data = regs[dbg_sel];
  assign hi_out   = hi;
  assign lo_out   = lo;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Scoreboard bench for bus_datapath_seq: one instance with a normal R0 and
// one with R0 hard-wired to zero. Stimulus pushes expected completions and
// state probes into queues; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_bus_datapath_seq;

  logic        clock = 1'b0;
  logic        clear, start0, start1;
  logic [2:0]  op;
  logic [3:0]  ra, rb, rc, dbg_sel0, dbg_sel1;
  logic [31:0] mdatain;
  logic        busy0, done0, busy1, done1;
  logic [31:0] bus_out0, dbg_data0, hi_out0, lo_out0;
  logic [31:0] bus_out1, dbg_data1, hi_out1, lo_out1;

  always #5 clock = ~clock;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .ZERO_R0(0)) u_dut0 (
    .clock(clock), .clear(clear), .start(start0), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .mdatain(mdatain), .busy(busy0), .done(done0), .bus_out(bus_out0),
    .dbg_sel(dbg_sel0), .dbg_data(dbg_data0), .hi_out(hi_out0), .lo_out(lo_out0));

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .ZERO_R0(1)) u_dut1 (
    .clock(clock), .clear(clear), .start(start1), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .mdatain(mdatain), .busy(busy1), .done(done1), .bus_out(bus_out1),
    .dbg_sel(dbg_sel1), .dbg_data(dbg_data1), .hi_out(hi_out1), .lo_out(lo_out1));

  typedef struct {
    string       name;
    int          acc;
    int          lat;
    int          kind;   // 0: register result, 1: HI/LO result
    int          idx;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  typedef struct {
    string       name;
    int          dut;
    int          kind;   // 0 reg, 1 hi, 2 lo, 3 busy, 4 done, 5 bus_out
    int          idx;
    logic [31:0] v;
  } probe_t;

  exp_t   q0[$];
  exp_t   q1[$];
  probe_t pq[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     end_req = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitor side ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic read_reg(input int d, input int idx, output logic [31:0] v);
    if (d == 0) begin dbg_sel0 = 4'(idx); #1; v = dbg_data0; end
    else        begin dbg_sel1 = 4'(idx); #1; v = dbg_data1; end
  endtask

  task automatic run_probe(input probe_t p);
    logic [31:0] v;
    case (p.kind)
      0: begin read_reg(p.dut, p.idx, v); chk(p.name, v, p.v); end
      1: chk(p.name, (p.dut == 0) ? hi_out0 : hi_out1, p.v);
      2: chk(p.name, (p.dut == 0) ? lo_out0 : lo_out1, p.v);
      3: chk(p.name, {31'b0, (p.dut == 0) ? busy0 : busy1}, p.v);
      4: chk(p.name, {31'b0, (p.dut == 0) ? done0 : done1}, p.v);
      default: chk(p.name, (p.dut == 0) ? bus_out0 : bus_out1, p.v);
    endcase
  endtask

  task automatic check_done(input int d, input exp_t e);
    logic [31:0] v;
    chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
    if (e.kind == 0) begin
      read_reg(d, e.idx, v);
      chk(e.name, v, e.v1);
    end else begin
      chk({e.name, "_hi"}, (d == 0) ? hi_out0 : hi_out1, e.v1);
      chk({e.name, "_lo"}, (d == 0) ? lo_out0 : lo_out1, e.v2);
    end
  endtask

  initial begin
    exp_t   e;
    probe_t p;
    dbg_sel0 = '0;
    dbg_sel1 = '0;
    forever begin
      @(negedge clock);
      while (pq.size() > 0) begin
        p = pq.pop_front();
        run_probe(p);
      end
      if (done0) begin
        if (q0.size() == 0) chk("spurious_done0", {31'b0, done0}, 32'd0);
        else begin e = q0.pop_front(); check_done(0, e); end
      end
      if (done1) begin
        if (q1.size() == 0) chk("spurious_done1", {31'b0, done1}, 32'd0);
        else begin e = q1.pop_front(); check_done(1, e); end
      end
      if (end_req) begin
        chk("pending_done0", 32'(q0.size()), 32'd0);
        chk("pending_done1", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  // ---------------- stimulus side ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input int d, input int k, input int idx, input logic [31:0] v, input string nm);
    probe_t p;
    p.name = nm; p.dut = d; p.kind = k; p.idx = idx; p.v = v;
    pq.push_back(p);
  endtask

  task automatic expect_op(input int d, input logic [2:0] o, input int a, input int acc,
                           input logic [31:0] v1, input logic [31:0] v2, input string nm);
    exp_t e;
    e.name = nm; e.acc = acc; e.idx = a; e.v1 = v1; e.v2 = v2;
    e.lat  = (o <= 3'd3) ? 3 : (o == 3'd4) ? 4 : (o == 3'd5) ? 2 : 1;
    e.kind = (o == 3'd4) ? 1 : 0;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (((d == 0) ? (busy0 | done0) : (busy1 | done1)) == 1'b0) return;
    end
    $display("FAIL wait_idle: dut%0d still busy after 40 cycles", d);
    $fatal(1, "sequencer timeout");
  endtask

  task automatic issue(input int d, input logic [2:0] o, input int a, input int b, input int c,
                       input logic [31:0] md, input logic [31:0] v1, input logic [31:0] v2,
                       input string nm);
    op = o; ra = 4'(a); rb = 4'(b); rc = 4'(c); mdatain = md;
    expect_op(d, o, a, cyc + 1, v1, v2, nm);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    wait_idle(d);
  endtask

  initial begin
    int acc;
    clear = 1'b1; start0 = 1'b0; start1 = 1'b0;
    op = '0; ra = '0; rb = '0; rc = '0; mdatain = '0;
    repeat (2) tick();
    clear = 1'b0;
    probe(0, 3, 0, 0, "init_busy0");
    probe(0, 4, 0, 0, "init_done0");
    probe(1, 3, 0, 0, "init_busy1");
    probe(0, 5, 0, 0, "init_bus_idle");
    tick();

    // Reset after a preload wipes everything
    issue(0, 3'd5, 3, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, "ldm_r3");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    probe(0, 1, 0, 0, "rst_hi");
    probe(0, 2, 0, 0, "rst_lo");
    probe(0, 3, 0, 0, "rst_busy");
    probe(0, 4, 0, 0, "rst_done");
    for (int i = 0; i < 16; i++) begin
      probe(0, 0, i, 0, $sformatf("rst_r%0d", i));
      tick();
    end

    // LDM then ADD with wraparound
    issue(0, 3'd5, 1, 0, 0, 32'h00000005, 32'h00000005, 0, "ldm_r1");
    issue(0, 3'd5, 2, 0, 0, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, "ldm_r2");
    issue(0, 3'd0, 4, 1, 2, 0, 32'h00000003, 0, "add_r4");

    // start held high: second op only accepted once back in IDLE
    op = 3'd0; ra = 4'd8; rb = 4'd1; rc = 4'd2;
    acc = cyc + 1;
    expect_op(0, 3'd0, 8, acc, 32'h00000003, 0, "b2b_add_r8");
    start0 = 1'b1;
    tick();
    op = 3'd3; ra = 4'd9;
    expect_op(0, 3'd3, 9, acc + 5, 32'hFFFFFFFF, 0, "b2b_or_r9");
    repeat (5) tick();
    start0 = 1'b0;
    wait_idle(0);

    // Signed multiply and moves from HI/LO
    issue(0, 3'd5, 1, 0, 0, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, "ldm_m3");
    issue(0, 3'd5, 2, 0, 0, 32'h00000007, 32'h00000007, 0, "ldm_7");
    issue(0, 3'd4, 10, 1, 2, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul");
    probe(0, 0, 10, 0, "mul_r10_untouched");
    tick();
    issue(0, 3'd7, 5, 0, 0, 0, 32'hFFFFFFEB, 0, "mflo_r5");
    issue(0, 3'd6, 11, 0, 0, 0, 32'hFFFFFFFF, 0, "mfhi_r11");

    // Aliasing and SUB
    issue(0, 3'd5, 6, 0, 0, 32'd10, 32'd10, 0, "ldm_r6");
    issue(0, 3'd5, 7, 0, 0, 32'd3, 32'd3, 0, "ldm_r7");
    issue(0, 3'd1, 6, 6, 7, 0, 32'd7, 0, "sub_alias_rb");
    issue(0, 3'd1, 7, 6, 7, 0, 32'd4, 0, "sub_alias_rc");

    // AND / OR
    issue(0, 3'd5, 12, 0, 0, 32'hF0F0F0F0, 32'hF0F0F0F0, 0, "ldm_r12");
    issue(0, 3'd5, 13, 0, 0, 32'h0FF00FF0, 32'h0FF00FF0, 0, "ldm_r13");
    issue(0, 3'd2, 14, 12, 13, 0, 32'h00F000F0, 0, "and_r14");
    issue(0, 3'd3, 15, 12, 13, 0, 32'hFFF0FFF0, 0, "or_r15");

    // Reset in T_Z aborts a MUL with no done pulse
    op = 3'd4; ra = 4'd10; rb = 4'd1; rc = 4'd2;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    probe(0, 1, 0, 0, "abort_hi");
    probe(0, 2, 0, 0, "abort_lo");
    probe(0, 3, 0, 0, "abort_busy");
    probe(0, 4, 0, 0, "abort_done");
    tick();
    probe(0, 0, 1, 0, "abort_r1");
    repeat (5) tick();
    issue(0, 3'd5, 1, 0, 0, 32'd5, 32'd5, 0, "post_ldm_r1");
    issue(0, 3'd5, 2, 0, 0, 32'd9, 32'd9, 0, "post_ldm_r2");
    issue(0, 3'd0, 3, 1, 2, 0, 32'h0000000E, 0, "post_add_r3");

    // R0 hard-wired to zero
    issue(1, 3'd5, 0, 0, 0, 32'h12345678, 32'h00000000, 0, "z_ldm_r0");
    issue(1, 3'd5, 1, 0, 0, 32'h00000055, 32'h00000055, 0, "z_ldm_r1");
    issue(1, 3'd0, 1, 0, 0, 0, 32'h00000000, 0, "z_add_r1");
    probe(1, 5, 0, 0, "z_bus_idle");
    tick();

    end_req = 1'b1;
    repeat (5) tick();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
